izh_update_engine: RTL
======================

# izh_update_engine

Sequential Izhikevich neuron update engine, directly downstream of the per-neuron constant register. On each `step` pulse it walks every neuron index. For each neuron it:
- reads that neuron's {a, b, c, d} word and input current;
- updates the neuron's private membrane state (v, u) with one shared fixed-point multiplier;
- reports spikes to the downstream synapse/event logic.

## Interface
Parameters:
- `NUMWIDTH`, 16: magnitude bits; every field is W = NUMWIDTH+1 bits signed.
- `NUMNEURONS`, 2: neuron count.
- `TAGBITS`, 1: neuron index width.
- `FRAC`, 8: fractional bits of all fixed-point values.
- `VPEAK`, 30<<FRAC: spike threshold.
- `VINIT`, -65<<FRAC: reset value of v.
- `UINIT`, -13<<FRAC: reset value of u.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `step`  in  1  start one timestep sweep; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `step` until `done`.
- `done`  out  1  one-cycle pulse after the last neuron's write-back.
- `const_tag`  out  TAGBITS  index presented to the constant register.
- `const_value`  in  4W  {a,b,c,d}, a in MSBs; combinational read of `const_tag`.
- `cur_tag`  out  TAGBITS  index presented to the current source.
- `cur_value`  in  W  signed input current I for `cur_tag`; combinational.
- `spike_valid`  out  1  one-cycle pulse: neuron `spike_tag` fired.
- `spike_tag`  out  TAGBITS  index of the firing neuron.

## Operation
- State memory: v[NUMNEURONS], u[NUMNEURONS], W-bit signed flops with async reset to VINIT/UINIT.
- FSM states: IDLE, FETCH, THRESH, M1, M2, M3, M4, SUM, WRITE.
- **IDLE**: on `step`, go to FETCH with idx=0.
- **FETCH**: drive `const_tag`=`cur_tag`=idx. Latch a, b, c, d, I, v[idx] and u[idx].
- **THRESH**:
  - If latched v >= VPEAK: v_new=c, u_new=u+d, pulse spike for idx, go to WRITE.
  - Otherwise go to M1.
- Multiplier pipeline; all products are 2W-bit signed with an arithmetic `>>> FRAC`:
  - **M1**: vv = v*v.
  - **M2**: q = K004*vv, with K004 = round(0.04*2^FRAC) = 10.
  - **M3**: bv = b*v.
  - **M4**: du = a*(bv-u).
- **SUM**, evaluated in 2W-bit arithmetic:
  - v_new = v + q + 5v + (140<<FRAC) - u + I
  - u_new = u + du
- **WRITE**:
  - Reduce v_new/u_new to W bits (see Configuration) and store them to idx.
  - If idx == NUMNEURONS-1: pulse `done` and go to IDLE. Otherwise idx++ and go to FETCH.
- `const_tag`/`cur_tag` hold idx in every state; they are 0 in IDLE.
- The spike check uses v stored at the previous step, so a spike is reported one step after v crosses VPEAK.

## Timing
- Reset values: `busy`=0, `done`=0, `spike_valid`=0, `spike_tag`=0, tags=0, state=IDLE.
- Per-neuron latency: 8 cycles on the non-spiking path, 3 cycles on the spiking path (FETCH, THRESH, WRITE).
- `step` is accepted in IDLE only. A `step` while busy is ignored, not queued.
- A `step` in the same cycle as `done` is also ignored.
- `spike_valid` is asserted in the WRITE cycle of the firing neuron. Spikes are one pulse each and never overlap.
- `const_value` and `cur_value` must be stable during FETCH only.
- Async reset mid-sweep returns the FSM to IDLE and v/u to VINIT/UINIT immediately. The partial sweep is discarded and no `done` is issued.

## Configuration
- `IZH_SAT_EN` defined: write-back saturates v_new/u_new to [-2^NUMWIDTH, 2^NUMWIDTH-1].
- `IZH_SAT_EN` undefined: write-back truncates to the low W bits (two's-complement wrap).

## Structure
- Package `izh_pkg` holds:
  - W and the field slice offsets of the 4W constant word;
  - K004, K5 and K140 fixed-point constants;
  - the FSM state enum.
- Sub-module `izh_fxmul`: W x 2W signed multiply followed by `>>> FRAC`. It is instantiated once and shared across M1-M4.

## Test plan
- **Reset:** assert `rst_n`=0 mid-sweep -> `busy`=0, `done`=0, `spike_valid`=0, state IDLE; the next sweep starts from v=-16640, u=-3328.
- **Subthreshold update:** a=b=0, I=0, NUMNEURONS=2, one `step` -> both v=-18422, both u=-3328, no spike; `done` pulses 16 cycles after `busy` rises.
- **Spike:** I=65280, c=-16640, d=2048.
  - Step 1 -> v=46858, no spike.
  - Step 2 -> `spike_valid` with `spike_tag`=idx, v=-16640, u=-1280, neuron latency 3 cycles.
- **Saturation:** I=-65536, a=b=0 -> v=-65536 with `IZH_SAT_EN`; v=47114 without it.
- **Ignored step:** pulse `step` every cycle during a sweep -> exactly one `done` per sweep, no extra sweeps.
- **Tag sequencing:** per-neuron distinct constants -> `const_tag`/`cur_tag` equal idx during each FETCH, and each neuron's result uses its own constants.

Source files
------------

// File: rtl/izh_pkg.sv
// Shared constants, constant-word field layout and FSM encoding for the Izhikevich update engine.
package izh_pkg;

    localparam int unsigned IZH_NUMWIDTH = 16;
    localparam int unsigned IZH_W        = IZH_NUMWIDTH + 1;
    localparam int unsigned IZH_FRAC     = 8;

    // Field positions (in units of W) inside the {a,b,c,d} constant word
    localparam int unsigned A_FLD = 3;
    localparam int unsigned B_FLD = 2;
    localparam int unsigned C_FLD = 1;
    localparam int unsigned D_FLD = 0;

    localparam int K004 = 10;
    localparam int K5   = 5;
    localparam int K140 = 140 << IZH_FRAC;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_THRESH,
        S_M1,
        S_M2,
        S_M3,
        S_M4,
        S_SUM,
        S_WRITE
    } izh_state_e;

endpackage

// File: rtl/izh_update_engine_fxmul.sv
// Shared signed fixed-point multiplier: W x 2W product, arithmetic shift right by FRAC, kept to 2W bits.
module izh_fxmul
    import izh_pkg::*;
#(
    parameter int unsigned W    = IZH_W,
    parameter int unsigned FRAC = IZH_FRAC
) (
    input  logic signed [W-1:0]   a_i,
    input  logic signed [2*W-1:0] b_i,
    output logic signed [2*W-1:0] p_c
);

    localparam int unsigned W2 = 2 * W;
    localparam int unsigned W3 = 3 * W;

    logic signed [W3-1:0] prod_c;

    always_comb begin
        prod_c = W3'(a_i) * W3'(b_i);
        p_c    = W2'(prod_c >>> FRAC);
    end

endmodule

// File: rtl/izh_update_engine.sv
// Sequential Izhikevich neuron update engine sweeping all neurons per step.
// Optional build macro IZH_SAT_EN: saturating write-back instead of two's-complement wrap.
module izh_update_engine
    import izh_pkg::*;
#(
    parameter int unsigned NUMWIDTH   = IZH_NUMWIDTH,
    parameter int unsigned NUMNEURONS = 2,
    parameter int unsigned TAGBITS    = 1,
    parameter int unsigned FRAC       = IZH_FRAC,
    parameter int          VPEAK      = 30 << FRAC,
    parameter int          VINIT      = (-65) << FRAC,
    parameter int          UINIT      = (-13) << FRAC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        step,
    output logic                        busy,
    output logic                        done,
    output logic [TAGBITS-1:0]          const_tag,
    input  logic [4*(NUMWIDTH+1)-1:0]   const_value,
    output logic [TAGBITS-1:0]          cur_tag,
    input  logic [NUMWIDTH:0]           cur_value,
    output logic                        spike_valid,
    output logic [TAGBITS-1:0]          spike_tag
);

    localparam int unsigned W  = NUMWIDTH + 1;
    localparam int unsigned W2 = 2 * W;

    izh_state_e state_q, state_d;
    logic [TAGBITS-1:0] idx_q, idx_d, spk_tag_q, spk_tag_d;
    logic busy_q, busy_d, done_q, done_d, spk_q, spk_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, i_q, i_d;
    logic signed [W-1:0] v_q, v_d, u_q, u_d, vn_q, vn_d, un_q, un_d;
    logic signed [W2-1:0] q_q, q_d, t_q, t_d;
    logic signed [W-1:0] v_mem_q [NUMNEURONS];
    logic signed [W-1:0] v_mem_d [NUMNEURONS];
    logic signed [W-1:0] u_mem_q [NUMNEURONS];
    logic signed [W-1:0] u_mem_d [NUMNEURONS];

    logic signed [W-1:0]  mul_a_c;
    logic signed [W2-1:0] mul_b_c, mul_p_c, u_add_c;
    logic signed [W-1:0]  v_fit_c, u_fit_c;

    izh_fxmul #(.W(W), .FRAC(FRAC)) u_mul (
        .a_i (mul_a_c),
        .b_i (mul_b_c),
        .p_c (mul_p_c)
    );

`ifdef IZH_SAT_EN
    localparam int SAT_MAX = (1 << NUMWIDTH) - 1;
    localparam int SAT_MIN = -(1 << NUMWIDTH);

    logic signed [W2-1:0] v_sum_c, u_sum_c;

    function automatic logic signed [W-1:0] sat_w(input logic signed [W2-1:0] x);
        if (x > W2'(SAT_MAX)) return W'(SAT_MAX);
        if (x < W2'(SAT_MIN)) return W'(SAT_MIN);
        return W'(x);
    endfunction
`endif

    // New v/u reduced to W bits; u adds d on the spike path, du otherwise
    always_comb begin
        u_add_c = (state_q == S_THRESH) ? W2'(d_q) : t_q;
`ifdef IZH_SAT_EN
        v_sum_c = W2'(v_q) + q_q + W2'(K5) * W2'(v_q) + W2'(K140) - W2'(u_q) + W2'(i_q);
        u_sum_c = W2'(u_q) + u_add_c;
        v_fit_c = sat_w(v_sum_c);
        u_fit_c = sat_w(u_sum_c);
`else
        v_fit_c = W'(W2'(v_q) + q_q + W2'(K5) * W2'(v_q) + W2'(K140) - W2'(u_q) + W2'(i_q));
        u_fit_c = W'(W2'(u_q) + u_add_c);
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        spk_d     = 1'b0;
        spk_tag_d = spk_tag_q;
        a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q; i_d = i_q;
        v_d = v_q; u_d = u_q; vn_d = vn_q; un_d = un_q;
        q_d = q_q; t_d = t_q;
        v_mem_d = v_mem_q;
        u_mem_d = u_mem_q;
        mul_a_c = a_q;
        mul_b_c = t_q;

        unique case (state_q)
            S_IDLE: begin
                // A step coinciding with the done pulse is dropped
                if (step && !done_q) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                a_d = const_value[A_FLD*W +: W];
                b_d = const_value[B_FLD*W +: W];
                c_d = const_value[C_FLD*W +: W];
                d_d = const_value[D_FLD*W +: W];
                i_d = cur_value;
                v_d = v_mem_q[idx_q];
                u_d = u_mem_q[idx_q];
                state_d = S_THRESH;
            end
            S_THRESH: begin
                if (v_q >= W'(VPEAK)) begin
                    vn_d      = c_q;
                    un_d      = u_fit_c;
                    spk_d     = 1'b1;
                    spk_tag_d = idx_q;
                    state_d   = S_WRITE;
                end else begin
                    state_d = S_M1;
                end
            end
            S_M1: begin
                mul_a_c = v_q;
                mul_b_c = W2'(v_q);
                t_d     = mul_p_c;
                state_d = S_M2;
            end
            S_M2: begin
                mul_a_c = W'(K004);
                mul_b_c = t_q;
                q_d     = mul_p_c;
                state_d = S_M3;
            end
            S_M3: begin
                mul_a_c = b_q;
                mul_b_c = W2'(v_q);
                t_d     = mul_p_c;
                state_d = S_M4;
            end
            S_M4: begin
                mul_a_c = a_q;
                mul_b_c = t_q - W2'(u_q);
                t_d     = mul_p_c;
                state_d = S_SUM;
            end
            S_SUM: begin
                vn_d    = v_fit_c;
                un_d    = u_fit_c;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                v_mem_d[idx_q] = vn_q;
                u_mem_d[idx_q] = un_q;
                if (idx_q == TAGBITS'(NUMNEURONS - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + TAGBITS'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            spk_q     <= 1'b0;
            spk_tag_q <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0; i_q <= '0;
            v_q <= '0; u_q <= '0; vn_q <= '0; un_q <= '0;
            q_q <= '0; t_q <= '0;
            for (int n = 0; n < NUMNEURONS; n++) begin
                v_mem_q[n] <= W'(VINIT);
                u_mem_q[n] <= W'(UINIT);
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            spk_q     <= spk_d;
            spk_tag_q <= spk_tag_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d; i_q <= i_d;
            v_q <= v_d; u_q <= u_d; vn_q <= vn_d; un_q <= un_d;
            q_q <= q_d; t_q <= t_d;
            v_mem_q <= v_mem_d;
            u_mem_q <= u_mem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign const_tag   = idx_q;
    assign cur_tag     = idx_q;
    assign spike_valid = spk_q;
    assign spike_tag   = spk_tag_q;

endmodule
